// File: rtl/alu_pkg.sv
// Shared types and defaults for the registered add/subtract stage.
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : alu_pkg

// File: rtl/alu_adder.sv
// Combinational width+1 bit adder with carry-in; the single arithmetic resource of the ALU.
module alu_adder
    import alu_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b_eff,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    logic [width:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b_eff} + {{width{1'b0}}, cin};
    assign sum     = total_s[width-1:0];
    assign cout    = total_s[width];

endmodule : alu_adder

// File: rtl/alu_addsub.sv
// Registered add/subtract stage with carry / no-borrow output.
// Define ALU_FLAGS_EN to add registered zero_out, neg_out and ovf_out flags.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] out,
    output logic             carry_out
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_out,
    output logic             neg_out,
    output logic             ovf_out
`endif
);

    alu_op_e          op_s;
    logic [width-1:0] b_eff_s;
    logic             cin_s;
    logic [width-1:0] sum_s;
    logic             cout_s;
    logic [width-1:0] out_r;
    logic             carry_r;

    assign op_s = alu_op_e'(s);

    // Subtraction reuses the adder as a + ~b + 1.
    always_comb begin
        b_eff_s = b;
        cin_s   = 1'b0;
        case (op_s)
            OP_ADD: begin
                b_eff_s = b;
                cin_s   = 1'b0;
            end
            OP_SUB: begin
                b_eff_s = ~b;
                cin_s   = 1'b1;
            end
            default: begin
                b_eff_s = b;
                cin_s   = 1'b0;
            end
        endcase
    end

    alu_adder #(
        .width (width)
    ) u_adder (
        .a     (a),
        .b_eff (b_eff_s),
        .cin   (cin_s),
        .sum   (sum_s),
        .cout  (cout_s)
    );

    // Result and carry registers; reset wins over any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r   <= {width{1'b0}};
            carry_r <= 1'b0;
        end else begin
            out_r   <= sum_s;
            carry_r <= cout_s;
        end
    end

    assign out       = out_r;
    assign carry_out = carry_r;

`ifdef ALU_FLAGS_EN
    logic zero_r;
    logic neg_r;
    logic ovf_r;
    logic ovf_s;

    // With b already conditionally inverted, both add and subtract overflow
    // reduce to: adder operands share a sign that the sum does not.
    assign ovf_s = (a[width-1] == b_eff_s[width-1]) && (sum_s[width-1] != a[width-1]);

    // Flag registers track the result registers cycle for cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            zero_r <= (sum_s == {width{1'b0}});
            neg_r  <= sum_s[width-1];
            ovf_r  <= ovf_s;
        end
    end

    assign zero_out = zero_r;
    assign neg_out  = neg_r;
    assign ovf_out  = ovf_r;
`endif

endmodule : alu_addsub

// File: tb/tb_alu_addsub.sv
// Scoreboard bench for alu_addsub (8-bit instance plus a 16-bit instance).
module tb_alu_addsub;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  out;
    logic        carry_out;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] out16;
    logic        carry16;
`ifdef ALU_FLAGS_EN
    logic        zero_out, neg_out, ovf_out;
    logic        zero16, neg16, ovf16;
`endif

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_addsub #(.width(8)) dut (
        .clk(clk), .reset(reset), .s(s), .a(a), .b(b),
        .out(out), .carry_out(carry_out)
`ifdef ALU_FLAGS_EN
        , .zero_out(zero_out), .neg_out(neg_out), .ovf_out(ovf_out)
`endif
    );

    alu_addsub #(.width(16)) dut16 (
        .clk(clk), .reset(reset), .s(s), .a(a16), .b(b16),
        .out(out16), .carry_out(carry16)
`ifdef ALU_FLAGS_EN
        , .zero_out(zero16), .neg_out(neg16), .ovf_out(ovf16)
`endif
    );

    // Reference model: integer arithmetic, borrow by comparison, overflow by range.
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic ms, input logic mr);
        exp_t e;
        int   ua, ub, sa, sbv, sr;
        e  = '0;
        ua = int'(ma);
        ub = int'(mb);
        sa = ua - ((ua >= 128) ? 256 : 0);
        sbv = ub - ((ub >= 128) ? 256 : 0);
        if (!mr) begin
            if (!ms) begin
                e.res = 8'((ua + ub) % 256);
                e.c   = (ua + ub) > 255;
                sr    = sa + sbv;
            end else begin
                e.res = 8'((ua - ub + 256) % 256);
                e.c   = (ua >= ub);
                sr    = sa - sbv;
            end
            e.z = (e.res == 8'h00);
            e.n = e.res[7];
            e.v = (sr > 127) || (sr < -128);
        end
        return e;
    endfunction

    task automatic drive(input logic [7:0] ta, input logic [7:0] tb_, input logic ts, input logic tr);
        @(negedge clk);
        a = ta; b = tb_; s = ts; reset = tr;
        sb.push_back(model(ta, tb_, ts, tr));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] ta[3] = '{8'hFF, 8'hFF, 8'hFF};
        logic       tr[3] = '{1'b1, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], 8'h01, 1'b0, tr[i]);
            e = sb.pop_front();
            checks++;
            if (out !== e.res || carry_out !== e.c) begin
                failures++;
                $display("FAIL reset[%0d] got out=%h c=%b expected out=%h c=%b", i, out, carry_out, e.res, e.c);
            end
        end
    endtask

    task automatic test_add();
        logic [7:0] ta[5] = '{8'h0F, 8'hFF, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] tb_[5] = '{8'h01, 8'h01, 8'hFF, 8'h01, 8'h80};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], tb_[i], 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (out !== e.res || carry_out !== e.c) begin
                failures++;
                $display("FAIL add[%0d] got out=%h c=%b expected out=%h c=%b", i, out, carry_out, e.res, e.c);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({zero_out, neg_out, ovf_out} !== {e.z, e.n, e.v}) begin
                failures++;
                $display("FAIL add_flags[%0d] got znv=%b%b%b expected znv=%b%b%b", i,
                         zero_out, neg_out, ovf_out, e.z, e.n, e.v);
            end
`endif
        end
    endtask

    task automatic test_sub();
        logic [7:0] ta[6] = '{8'h20, 8'h10, 8'h55, 8'h00, 8'h80, 8'h00};
        logic [7:0] tb_[6] = '{8'h10, 8'h20, 8'h55, 8'h00, 8'h01, 8'hFF};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drive(ta[i], tb_[i], 1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (out !== e.res || carry_out !== e.c) begin
                failures++;
                $display("FAIL sub[%0d] got out=%h c=%b expected out=%h c=%b", i, out, carry_out, e.res, e.c);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({zero_out, neg_out, ovf_out} !== {e.z, e.n, e.v}) begin
                failures++;
                $display("FAIL sub_flags[%0d] got znv=%b%b%b expected znv=%b%b%b", i,
                         zero_out, neg_out, ovf_out, e.z, e.n, e.v);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] ta[3] = '{8'h08, 8'h50, 8'h50};
        logic [7:0] tb_[3] = '{8'h08, 8'h25, 8'h25};
        logic       tr[3] = '{1'b0, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb_[i], 1'b0, tr[i]);
            e = sb.pop_front();
            checks++;
            if (out !== e.res || carry_out !== e.c) begin
                failures++;
                $display("FAIL mid_reset[%0d] got out=%h c=%b expected out=%h c=%b", i, out, carry_out, e.res, e.c);
            end
            if (i == 0) begin
                // Result must hold until the next edge even when inputs move.
                a = 8'hC3; b = 8'h3C; s = 1'b1;
                @(negedge clk);
                checks++;
                if (out !== e.res || carry_out !== e.c) begin
                    failures++;
                    $display("FAIL hold got out=%h c=%b expected out=%h c=%b", out, carry_out, e.res, e.c);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0);
            e = sb.pop_front();
            checks++;
            if (out !== e.res || carry_out !== e.c) begin
                failures++;
                $display("FAIL b2b[%0d] a=%h b=%h s=%b got out=%h c=%b expected out=%h c=%b",
                         i, a, b, s, out, carry_out, e.res, e.c);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({zero_out, neg_out, ovf_out} !== {e.z, e.n, e.v}) begin
                failures++;
                $display("FAIL b2b_flags[%0d] got znv=%b%b%b expected znv=%b%b%b", i,
                         zero_out, neg_out, ovf_out, e.z, e.n, e.v);
            end
`endif
        end
    endtask

    task automatic test_width16();
        logic [15:0] ta[2] = '{16'hFFFF, 16'h1234};
        logic [15:0] tb_[2] = '{16'h0001, 16'h1235};
        logic        ts[2] = '{1'b0, 1'b1};
        logic [15:0] er[2] = '{16'h0000, 16'hFFFF};
        logic        ec[2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a16 = ta[i]; b16 = tb_[i]; s = ts[i]; reset = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (out16 !== er[i] || carry16 !== ec[i]) begin
                failures++;
                $display("FAIL w16[%0d] got out=%h c=%b expected out=%h c=%b", i, out16, carry16, er[i], ec[i]);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if (zero16 !== (er[i] == 16'h0000) || neg16 !== er[i][15]) begin
                failures++;
                $display("FAIL w16_flags[%0d] got z=%b n=%b", i, zero16, neg16);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; a = 8'h00; b = 8'h00; a16 = 16'h0000; b16 = 16'h0000;
        test_reset();
        test_add();
        test_sub();
        test_mid_reset();
        test_back_to_back();
        test_width16();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_addsub

// File: doc/alu_addsub.md
Name: alu_addsub

Overview:
Registered add/subtract unit with carry output. Width is parameterised.
- Operands a and b are combined under control of op-select s.
- Result and carry are captured on the rising clock edge.
- Sits in the datapath as a single-cycle arithmetic stage; downstream logic consumes registered outputs only.

Parameters:
width, 8, operand/result bit width (>=2)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous active-high reset
s  input  1  operation select: 0 = add, 1 = subtract
a  input  width  operand A (unsigned, two's-complement compatible)
b  input  width  operand B
out  output  width  registered result
carry_out  output  1  registered carry (add) / no-borrow (subtract)

Behaviour:
- Single clock domain; all state updates on the rising edge of clk only.
- Reset:
  - reset=1 at an edge: out <= 0, carry_out <= 0.
  - Reset has priority over any operation in the same cycle.
  - Reset mid-operation discards the in-flight computation; no partial result survives.
- Add (s=0): {carry_out,out} <= a + b, computed at width+1 bits.
  - carry_out = bit width of the sum.
- Subtract (s=1): {carry_out,out} <= a + ~b + 1, computed at width+1 bits.
  - carry_out=1 means no borrow (a >= b unsigned).
  - carry_out=0 means borrow (a < b).
- Implementation: one shared adder. b is conditionally inverted by s; s is used as carry-in. No separate subtractor.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on out/carry_out after edge N, and are held until the next edge.
- Throughput: one operation per cycle; no handshake; every non-reset edge loads a new result.
- Outputs are pure registers; no combinational path from inputs to outputs.
- Wrap-around: result is modulo 2^width.
  - Overflow beyond width is reported only via carry_out (and via ovf_out when the optional feature is compiled in).
- Boundaries:
  - a=b in subtract -> out=0, carry_out=1.
  - a=0, b=0 in subtract -> out=0, carry_out=1.
  - All-ones + 1 -> out=0, carry_out=1.
- Inputs are X-free during reset deassertion; outputs are never X after the first reset edge.

Optional Feature:
ALU_FLAGS_EN
- Defined: adds three registered 1-bit outputs, all reset to 0 and updated on the same edge with the same latency as out.
  - zero_out: 1 when the next out == 0.
  - neg_out: MSB of the next out.
  - ovf_out: signed two's-complement overflow.
    - Add: a and b have the same sign and the result sign differs.
    - Subtract: a and b have different signs and the result sign differs from a.
- Undefined: these ports and their logic do not exist; the port list is exactly as above.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} alu_op_e
  - localparam DEFAULT_WIDTH = 8
- One natural sub-module: alu_adder. It is purely combinational, parameterised by width, with inputs a, b_eff, cin and outputs sum[width-1:0], cout.
- The top level holds the operand inversion, output registers, reset logic and optional flag logic.

Test Plan:
- Reset: reset=1 for 2 edges with a=FF, b=01, s=0 -> out=00, carry_out=0 throughout; release -> next edge out=00, carry_out=1.
- Add without carry: a=0F, b=01, s=0 -> one edge later out=10, carry_out=0.
- Add with carry/wrap: a=FF, b=01, s=0 -> out=00, carry_out=1. Then a=FF, b=FF -> out=FE, carry_out=1.
- Subtract:
  - a=20, b=10, s=1 -> out=10, carry_out=1.
  - a=10, b=20, s=1 -> out=F0, carry_out=0.
  - a=b=55, s=1 -> out=00, carry_out=1.
- Reset mid-stream: result 10 held, then assert reset with a=50, b=25, s=0 -> out=00, carry_out=0. Deassert -> next edge out=75, carry_out=0. Checks reset priority and 1-cycle latency.
- With ALU_FLAGS_EN:
  - a=7F, b=01, s=0 -> out=80, ovf_out=1, neg_out=1, zero_out=0.
  - a=80, b=01, s=1 -> out=7F, ovf_out=1.
  - width=16 elaboration: FFFF+0001 -> out=0000, carry_out=1, zero_out=1.
